// File: rtl/i2c_slave.sv
// i2c_slave: oversampling I2C target. Synchronises SCL/SDA to clk, detects
// START/STOP and SCL edges, matches a 7-bit address, ACKs, collects write
// bytes and serves read bytes MSB-first. SDA is open-drain via sda_oe.
`timescale 1ns/1ps
module i2c_slave #(
  parameter int                  ADDR_BIT   = 7,
  parameter logic [ADDR_BIT-1:0] SLAVE_ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       addr_match
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ACK_ADDR, WR_DATA, ACK_WR, RD_DATA, ACK_RD, WAIT_STOP
  } state_t;

  state_t     state;
  logic [2:0] scl_sync;   // [1] is the synchronised level, [2] its delayed copy
  logic [2:0] sda_sync;
  logic [2:0] bit_cnt;
  logic       byte_done;  // 8 bits shifted, waiting for the closing scl_fall
  logic       rw;
  logic [7:0] shift_reg;
  logic [6:0] tx_shift;   // remaining read bits after the one on the wire

  logic scl_rise, scl_fall, start_det, stop_det, addr_hit;

  assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
  assign start_det =  scl_sync[1] &  scl_sync[2] & ~sda_sync[1] &  sda_sync[2];
  assign stop_det  =  scl_sync[1] &  scl_sync[2] &  sda_sync[1] & ~sda_sync[2];
  assign addr_hit  = (shift_reg[7 -: ADDR_BIT] == SLAVE_ADDR);

  // Two-flop synchronisers plus one delay flop for edge detection.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: preset to 1 (idle bus level) so leaving reset never fakes an edge.
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value.
      scl_sync <= {scl_sync[1:0], scl_in};
      sda_sync <= {sda_sync[1:0], sda_in};
    end
  end

  // Protocol state machine with registered outputs; START/STOP override bit handling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      sda_oe     <= 1'b0;
      tx_req     <= 1'b0;
      rx_data    <= 8'h00;
      rx_valid   <= 1'b0;
      busy       <= 1'b0;
      addr_match <= 1'b0;
      bit_cnt    <= 3'd0;
      byte_done  <= 1'b0;
      rw         <= 1'b0;
      shift_reg  <= 8'h00;
      tx_shift   <= 7'h00;
    end else begin
      // NOTE: pulse outputs default low every cycle; branches below raise them for one clk.
      tx_req   <= 1'b0;
      rx_valid <= 1'b0;
      if (stop_det) begin
        state      <= IDLE;
        sda_oe     <= 1'b0;
        busy       <= 1'b0;
        addr_match <= 1'b0;
        byte_done  <= 1'b0;
      end else if (start_det) begin
        state      <= ADDR;
        busy       <= 1'b1;
        sda_oe     <= 1'b0;
        addr_match <= 1'b0;
        bit_cnt    <= 3'd0;
        byte_done  <= 1'b0;
      end else begin
        case (state)
          IDLE, WAIT_STOP: ;
          ADDR, WR_DATA: begin
            if (scl_rise) begin
              shift_reg <= {shift_reg[6:0], sda_sync[1]};
              bit_cnt   <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) byte_done <= 1'b1;
            end else if (scl_fall && byte_done) begin
              byte_done <= 1'b0;
              bit_cnt   <= 3'd0;
              if (state == ADDR) begin
                rw <= shift_reg[0];
                if (addr_hit) begin
                  state      <= ACK_ADDR;
                  sda_oe     <= 1'b1;
                  addr_match <= 1'b1;
                end else begin
                  state  <= WAIT_STOP;
                  sda_oe <= 1'b0;
                end
              end else begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
                sda_oe   <= 1'b1;
                state    <= ACK_WR;
              end
            end
          end
          ACK_ADDR: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (rw) begin
                tx_shift <= tx_data[6:0];
                tx_req   <= 1'b1;
                sda_oe   <= ~tx_data[7];
                state    <= RD_DATA;
              end else begin
                sda_oe <= 1'b0;
                state  <= WR_DATA;
              end
            end
          end
          ACK_WR: begin
            if (scl_fall) begin
              sda_oe  <= 1'b0;
              bit_cnt <= 3'd0;
              state   <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe  <= 1'b0;
                bit_cnt <= 3'd0;
                state   <= ACK_RD;
              end else begin
                sda_oe   <= ~tx_shift[6];
                tx_shift <= {tx_shift[5:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
              end
            end
          end
          ACK_RD: begin
            // A NACK ends the read; reaching the next fall here means the master ACKed.
            if (scl_rise && sda_sync[1]) begin
              state <= WAIT_STOP;
            end else if (scl_fall) begin
              tx_shift <= tx_data[6:0];
              tx_req   <= 1'b1;
              sda_oe   <= ~tx_data[7];
              bit_cnt  <= 3'd0;
              state    <= RD_DATA;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// tb_i2c_slave: bit-banged I2C master driving i2c_slave over a wired-AND SDA
// line, with a transaction-level reference model for ACKs, read bytes and
// write bytes.
`timescale 1ns/1ps
module tb_i2c_slave;

  localparam logic [6:0] OWN_ADDR = 7'h42;
  typedef logic [7:0] byte_q_t [$];

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       scl     = 1'b1;
  logic       sda_m   = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       sda_oe, tx_req, rx_valid, busy, addr_match;
  logic [7:0] rx_data;
  logic       sda_line;

  assign sda_line = sda_m & ~sda_oe;

  int vectors     = 0;
  int miscompares = 0;

  int         rx_count     = 0;
  int         tx_count     = 0;
  int         oe_cycles    = 0;
  int         match_cycles = 0;
  int         oe_glitches  = 0;
  logic       oe_prev      = 1'b0;
  logic [7:0] rx_log [$];

  i2c_slave #(.ADDR_BIT(7), .SLAVE_ADDR(OWN_ADDR)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .scl_in     (scl),
    .sda_in     (sda_line),
    .sda_oe     (sda_oe),
    .tx_data    (tx_data),
    .tx_req     (tx_req),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .busy       (busy),
    .addr_match (addr_match)
  );

  always #5 clk = ~clk;

  // Bookkeeping of pulses and SDA drive, sampled away from the active edge.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_count <= rx_count + 1;
      rx_log.push_back(rx_data);
    end
    if (tx_req)     tx_count     <= tx_count + 1;
    if (sda_oe)     oe_cycles    <= oe_cycles + 1;
    if (addr_match) match_cycles <= match_cycles + 1;
    if (reset_n && (sda_oe !== oe_prev) && scl) oe_glitches <= oe_glitches + 1;
    oe_prev <= sda_oe;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One SCL period: data set early in the low phase, sampled mid-high.
  task automatic clock_bit(input logic b, output logic s, output logic oe);
    #60  sda_m = b;
    #140 scl = 1'b1;
    #100 begin s = sda_line; oe = sda_oe; end
    #100 scl = 1'b0;
  endtask

  task automatic bus_start();
    scl = 1'b0;
    #100 sda_m = 1'b1;
    #100 scl = 1'b1;
    #100 sda_m = 1'b0;
    #100 scl = 1'b0;
  endtask

  task automatic bus_stop();
    #100 sda_m = 1'b0;
    #100 scl = 1'b1;
    #100 sda_m = 1'b1;
    #200;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s, oe;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s, oe);
    clock_bit(1'b1, s, oe);
    ack = oe & ~s;
  endtask

  task automatic read_byte(input logic master_ack, input logic [7:0] next_tx,
                           output logic [7:0] b);
    logic s, oe;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s, oe);
      b[i] = s;
    end
    tx_data = next_tx;
    clock_bit(~master_ack, s, oe);
  endtask

  // Full write transaction; the model expects ACKs and stored bytes only on an address hit.
  task automatic run_write(input logic [6:0] addr7, input byte_q_t data, input string tag);
    logic hit, ack;
    int   rx0, oe0, m0, n;
    hit = (addr7 == OWN_ADDR);
    n   = data.size();
    rx0 = rx_count; oe0 = oe_cycles; m0 = match_cycles;
    bus_start();
    check({tag, "/busy_start"}, 32'(busy), 32'(1));
    write_byte({addr7, 1'b0}, ack);
    check({tag, "/addr_ack"}, 32'(ack), 32'(hit));
    check({tag, "/addr_match"}, 32'(addr_match), 32'(hit));
    for (int i = 0; i < n; i++) begin
      write_byte(data[i], ack);
      check({tag, "/data_ack"}, 32'(ack), 32'(hit));
    end
    bus_stop();
    check({tag, "/busy_stop"}, 32'(busy), 32'(0));
    check({tag, "/match_stop"}, 32'(addr_match), 32'(0));
    check({tag, "/oe_stop"}, 32'(sda_oe), 32'(0));
    check({tag, "/rx_pulses"}, 32'(rx_count - rx0), hit ? 32'(n) : 32'(0));
    if (hit) begin
      for (int i = 0; i < n; i++) check({tag, "/rx_byte"}, 32'(rx_log[rx0 + i]), 32'(data[i]));
      check({tag, "/rx_data"}, 32'(rx_data), 32'(data[n-1]));
    end else begin
      check({tag, "/oe_never"}, 32'(oe_cycles - oe0), 32'(0));
      check({tag, "/match_never"}, 32'(match_cycles - m0), 32'(0));
    end
  endtask

  // Full read transaction; master ACKs every byte but the last.
  task automatic run_read(input logic [6:0] addr7, input byte_q_t data, input string tag);
    logic       hit, ack;
    logic [7:0] got, nxt;
    int         tx0, rx0, n;
    hit = (addr7 == OWN_ADDR);
    n   = data.size();
    tx0 = tx_count; rx0 = rx_count;
    tx_data = data[0];
    bus_start();
    write_byte({addr7, 1'b1}, ack);
    check({tag, "/addr_ack"}, 32'(ack), 32'(hit));
    check({tag, "/addr_match"}, 32'(addr_match), 32'(hit));
    for (int i = 0; i < n; i++) begin
      nxt = (i + 1 < n) ? data[i+1] : 8'h00;
      read_byte(i != n - 1, nxt, got);
      check({tag, "/rd_byte"}, 32'(got), hit ? 32'(data[i]) : 32'hFF);
    end
    #100;
    check({tag, "/oe_after_nack"}, 32'(sda_oe), 32'(0));
    bus_stop();
    check({tag, "/busy_stop"}, 32'(busy), 32'(0));
    check({tag, "/tx_pulses"}, 32'(tx_count - tx0), hit ? 32'(n) : 32'(0));
    check({tag, "/rx_pulses"}, 32'(rx_count - rx0), 32'(0));
  endtask

  initial begin
    byte_q_t    q;
    logic       ack, s, oe;
    logic [7:0] got, t;
    int         rx0, nb;
    logic [6:0] a7;

    // Reset state.
    #47;
    check("rst/sda_oe", 32'(sda_oe), 32'(0));
    check("rst/tx_req", 32'(tx_req), 32'(0));
    check("rst/rx_valid", 32'(rx_valid), 32'(0));
    check("rst/busy", 32'(busy), 32'(0));
    check("rst/addr_match", 32'(addr_match), 32'(0));
    check("rst/rx_data", 32'(rx_data), 32'(0));
    reset_n = 1'b1;
    #200;

    q.delete(); q.push_back(8'hA5);
    run_write(OWN_ADDR, q, "write");

    q.delete(); q.push_back(8'h3C); q.push_back(8'hC3);
    run_read(OWN_ADDR, q, "read");

    q.delete(); q.push_back(8'h11); q.push_back(8'h22);
    run_write(7'h43, q, "mismatch");

    // Repeated START after half a data byte: partial byte dropped, read proceeds.
    rx0 = rx_count;
    t   = 8'($urandom);
    bus_start();
    write_byte(8'h84, ack);
    check("rs/addr_ack_w", 32'(ack), 32'(1));
    for (int i = 0; i < 4; i++) clock_bit(1'($urandom), s, oe);
    tx_data = t;
    bus_start();
    check("rs/match_cleared", 32'(addr_match), 32'(0));
    check("rs/busy_held", 32'(busy), 32'(1));
    write_byte(8'h85, ack);
    check("rs/addr_ack_r", 32'(ack), 32'(1));
    read_byte(1'b0, 8'h00, got);
    check("rs/rd_byte", 32'(got), 32'(t));
    bus_stop();
    check("rs/rx_pulses", 32'(rx_count - rx0), 32'(0));

    // STOP in the middle of a data byte.
    rx0 = rx_count;
    bus_start();
    write_byte(8'h84, ack);
    for (int i = 0; i < 3; i++) clock_bit(1'($urandom), s, oe);
    bus_stop();
    check("stopmid/busy", 32'(busy), 32'(0));
    check("stopmid/match", 32'(addr_match), 32'(0));
    check("stopmid/rx_pulses", 32'(rx_count - rx0), 32'(0));

    // Reset while the target pulls SDA low for a 0 read bit.
    tx_data = 8'h3C;
    bus_start();
    write_byte(8'h85, ack);
    #100;
    check("rstmid/driving0", 32'(sda_oe), 32'(1));
    reset_n = 1'b0;
    #1;
    check("rstmid/sda_oe", 32'(sda_oe), 32'(0));
    check("rstmid/busy", 32'(busy), 32'(0));
    check("rstmid/addr_match", 32'(addr_match), 32'(0));
    check("rstmid/rx_data", 32'(rx_data), 32'(0));
    check("rstmid/tx_req", 32'(tx_req), 32'(0));
    check("rstmid/rx_valid", 32'(rx_valid), 32'(0));
    scl   = 1'b1;
    sda_m = 1'b1;
    #50 reset_n = 1'b1;
    #200;
    q.delete(); q.push_back(8'($urandom));
    run_write(OWN_ADDR, q, "post_reset");

    // Randomised transactions against the model.
    for (int k = 0; k < 6; k++) begin
      a7 = ($urandom_range(0, 1) == 1) ? OWN_ADDR : 7'($urandom);
      nb = $urandom_range(1, 3);
      q.delete();
      for (int i = 0; i < nb; i++) q.push_back(8'($urandom));
      if ($urandom_range(0, 1) == 1) run_read(a7, q, "rand_rd");
      else                           run_write(a7, q, "rand_wr");
    end

    check("oe_changed_scl_high", 32'(oe_glitches), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2c_slave.md
Name: i2c_slave

Overview:
- I2C target (slave) that answers the bus master at the far end of the SCL/SDA wires.
- Runs on a fast system clock and oversamples SCL/SDA.
- Detects START/STOP, matches its 7-bit address, ACKs, receives write bytes and returns read bytes MSB-first.
- Drives SDA open-drain only: sda_oe=1 pulls low, otherwise released.

Parameters:
- ADDR_BIT, 7, address width in bits.
- SLAVE_ADDR, 7'h42, this target's bus address.

Ports:
- clk  input  1  system clock; must be at least 10x the SCL frequency.
- reset_n  input  1  asynchronous active-low reset.
- scl_in  input  1  raw SCL from the pad.
- sda_in  input  1  raw SDA from the pad.
- sda_oe  output  1  1 = pull SDA low; 0 = release.
- tx_data  input  8  byte to return on a read; sampled when tx_req pulses.
- tx_req  output  1  one-clk pulse when tx_data is loaded.
- rx_data  output  8  last byte written by the master.
- rx_valid  output  1  one-clk pulse when rx_data is updated.
- busy  output  1  high from START until STOP.
- addr_match  output  1  high from address ACK until STOP or repeated START.

Behaviour:
- Reset (async, reset_n=0):
  - sda_oe=0, tx_req=0, rx_valid=0, busy=0, addr_match=0, rx_data=8'h00.
  - State=IDLE; synchronizers preset to 1.
  - Reset mid-transfer releases SDA immediately.
- Input sync: scl_in and sda_in each pass through 2 flops, then a 3rd flop for edge detect.
- Events, each valid for 1 clk:
  - scl_rise, scl_fall.
  - START = synced sda falls while synced scl=1.
  - STOP = synced sda rises while synced scl=1.
- Sampling rules:
  - SDA is sampled only on scl_rise.
  - sda_oe changes only on scl_fall, except the forced releases on START, STOP and reset.
- Bit counter: 3 bits, counts 0..7 over 8 bits, cleared on entry to every byte state.
- States: IDLE, ADDR, ACK_ADDR, WR_DATA, ACK_WR, RD_DATA, ACK_RD, WAIT_STOP.
  - IDLE: START -> ADDR, busy=1.
  - ADDR:
    - Shift 8 bits MSB-first (7-bit address, then R/W).
    - On the scl_fall after the 8th bit: if address == SLAVE_ADDR -> ACK_ADDR, sda_oe=1, addr_match=1.
    - Otherwise -> WAIT_STOP with sda_oe=0.
  - ACK_ADDR, on the next scl_fall:
    - R/W=0: sda_oe=0 -> WR_DATA.
    - R/W=1: load tx_data, pulse tx_req, sda_oe=~tx_data[7] -> RD_DATA.
  - WR_DATA:
    - Shift 8 bits on scl_rise.
    - On the scl_fall after bit 8: rx_data=shifted byte, rx_valid pulses, sda_oe=1 -> ACK_WR.
    - Every written byte is ACKed.
  - ACK_WR: on the next scl_fall, sda_oe=0 -> WR_DATA.
  - RD_DATA:
    - On each scl_fall, drive the next bit: sda_oe=~bit.
    - After bit 0's scl_fall, sda_oe=0 -> ACK_RD.
  - ACK_RD: sample the master's ACK on scl_rise.
    - 0 (ACK): on the next scl_fall, load tx_data, pulse tx_req, drive bit 7 -> RD_DATA.
    - 1 (NACK): -> WAIT_STOP, SDA stays released.
  - WAIT_STOP: ignore everything but START and STOP.
- START in any non-IDLE state (repeated start) -> ADDR:
  - sda_oe=0, addr_match=0, bit counter cleared.
  - A partial byte is discarded; no rx_valid.
- STOP in any state -> IDLE:
  - sda_oe=0, busy=0, addr_match=0.
  - A partial byte is discarded.
- Simultaneous START/STOP and scl_fall cannot occur, because SCL is high during both. START/STOP take priority over bit handling.
- Latency: 3 clk from pad edge to event; sda_oe update 1 clk after scl_fall.

Test Plan:
- Write: START, 0x84 (addr 0x42 + W), byte 0xA5, STOP.
  -> sda_oe=1 during both 9th bits; rx_data=0xA5; one rx_valid pulse; busy falls after STOP.
- Read: START, 0x85, tx_data=0x3C, master ACK, tx_data=0xC3, master NACK, STOP.
  -> SDA carries 0x3C then 0xC3 MSB-first; tx_req pulses twice; sda_oe=0 after NACK.
- Mismatch: START, 0x86 (addr 0x43), 2 bytes, STOP.
  -> sda_oe never 1; rx_valid never; addr_match stays 0.
- Repeated start: write 0x84, 4 bits of a data byte, then START, 0x85 read.
  -> no rx_valid; ACK on the new address; read proceeds.
- STOP mid-byte, and reset_n=0 mid-read while driving a 0.
  -> STOP returns to IDLE with busy=0; reset drives sda_oe=0 immediately, all outputs at reset values, and the next START is handled normally.
